pc_fetch_sequencer: RTL and testbench
=====================================

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, program counter and fetch address width.
REQ-002 Parameter INSTR_WIDTH, default 16, instruction word width.
REQ-003 Parameter CNT_WIDTH, default 16, retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-high.
REQ-006 Start  input  1  one-cycle pulse; begins execution at StartPC; accepted only in IDLE or DONE.
REQ-007 StartPC  input  PC_WIDTH  initial PC, sampled on accepted Start.
REQ-008 MemReqValid  output  1  fetch request valid.
REQ-009 MemReqReady  input  1  program memory accepts request.
REQ-010 MemAddr  output  PC_WIDTH  fetch address; equals current PC.
REQ-011 MemRspValid  input  1  instruction returned.
REQ-012 MemRspData  input  INSTR_WIDTH  returned instruction.
REQ-013 Instr  output  INSTR_WIDTH  held instruction for the execute stage.
REQ-014 ExecValid  output  1  Instr valid, execute stage may run.
REQ-015 ExecDone  input  1  execute stage finished current instruction.
REQ-016 BranchTaken  input  1  qualified by ExecDone; redirect PC.
REQ-017 BranchTarget  input  PC_WIDTH  redirect address.
REQ-018 Halt  input  1  qualified by ExecDone; stop after current instruction.
REQ-019 CurrentPC  output  PC_WIDTH  architectural PC.
REQ-020 Busy  output  1  high in FETCH, WAIT_RSP, EXEC.
REQ-021 Done  output  1  high in DONE.
REQ-022 PcWrap  output  1  sticky; set when sequential increment wraps all-ones to 0.
REQ-023 RetiredCount  output  CNT_WIDTH  instructions completed since last Start, saturating.

Function
REQ-024 States: IDLE, FETCH, WAIT_RSP, EXEC, DONE; encoded as enum.
REQ-025 IDLE/DONE + Start -> FETCH; PC<=StartPC, PcWrap<=0, RetiredCount<=0, Done drops next cycle.
REQ-026 Start in FETCH, WAIT_RSP or EXEC is ignored; no state change.
REQ-027 FETCH: MemReqValid=1, MemAddr=PC; on MemReqReady -> WAIT_RSP (request held stable until accepted).
REQ-028 WAIT_RSP: MemReqValid=0; on MemRspValid capture MemRspData into Instr, -> EXEC.
REQ-029 MemRspValid outside WAIT_RSP is ignored.
REQ-030 EXEC: ExecValid=1, Instr stable; waits any number of cycles for ExecDone.
REQ-031 ExecDone with Halt=1 -> DONE; PC unchanged; RetiredCount increments.
REQ-032 ExecDone with Halt=0, BranchTaken=1 -> FETCH; PC<=BranchTarget.
REQ-033 ExecDone with Halt=0, BranchTaken=0 -> FETCH; PC<=PC+1 modulo 2^PC_WIDTH.
REQ-034 Halt and BranchTaken both high: Halt wins, branch ignored.
REQ-035 Sequential increment from all-ones: PC<=0, PcWrap<=1, execution continues.
REQ-036 Branch to any target never sets PcWrap.
REQ-037 RetiredCount +1 on every ExecDone in EXEC; holds at all-ones.
REQ-038 Minimum fetch-to-fetch period: 3 cycles (FETCH, WAIT_RSP, EXEC each one cycle with same-cycle ready/response/done).
REQ-039 ExecDone, BranchTaken, Halt outside EXEC are ignored.

Reset
REQ-040 reset asserted: state IDLE, PC=0, Instr=0, RetiredCount=0, PcWrap=0; all outputs low/zero immediately, independent of clk.
REQ-041 reset mid-fetch or mid-exec abandons the transaction; no request is reissued until a new Start.

Structure
REQ-042 Shared package holds state enum type and default PC_WIDTH/INSTR_WIDTH constants.
REQ-043 Sequential increment uses the existing combinational PC+1 incrementer instantiated as one sub-module; wrap detected as CurrentPC all-ones on increment.

Verification
REQ-044 reset; Start, StartPC=0x10, zero-wait memory, ExecDone immediately, 3 instrs then Halt -> MemAddr 0x10,0x11,0x12; Done; RetiredCount=3; CurrentPC=0x12.
REQ-045 Branch: at PC=0x05 ExecDone+BranchTaken, BranchTarget=0x40 -> next MemAddr=0x40; PcWrap=0.
REQ-046 Wrap: StartPC=0xFF, one sequential ExecDone -> MemAddr=0x00, PcWrap=1; next Start clears PcWrap.
REQ-047 Backpressure: MemReqReady low 4 cycles, MemRspValid delayed 3 cycles -> MemReqValid/MemAddr stable throughout; Instr equals returned data; one retirement.
REQ-048 Halt+BranchTaken together at PC=0x08 -> DONE, CurrentPC=0x08; Start during Busy ignored.
REQ-049 reset asserted asynchronously in WAIT_RSP -> outputs zero before next clk edge; late MemRspValid ignored; state IDLE.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and default widths for the fetch sequencer and its helpers.
package pc_fetch_sequencer_pkg;

  localparam int DEFAULT_PC_WIDTH    = 8;
  localparam int DEFAULT_INSTR_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RSP,
    ST_EXEC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pc_fetch_sequencer_inc.sv
// Combinational PC incrementer; pc_max flags the all-ones value that wraps to zero.
module pc_fetch_sequencer_inc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic             pc_max
);

  assign pc_plus1 = pc + 1'b1;
  assign pc_max   = &pc;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Single-issue fetch/execute sequencer: fetches at PC, holds the instruction for
// the execute stage, then steps, branches or halts on ExecDone.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [PC_WIDTH-1:0]    StartPC,
  output logic                   MemReqValid,
  input  logic                   MemReqReady,
  output logic [PC_WIDTH-1:0]    MemAddr,
  input  logic                   MemRspValid,
  input  logic [INSTR_WIDTH-1:0] MemRspData,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic                   ExecValid,
  input  logic                   ExecDone,
  input  logic                   BranchTaken,
  input  logic [PC_WIDTH-1:0]    BranchTarget,
  input  logic                   Halt,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic                   Busy,
  output logic                   Done,
  output logic                   PcWrap,
  output logic [CNT_WIDTH-1:0]   RetiredCount
);

  state_t                 state_reg, state_next;
  logic [PC_WIDTH-1:0]    pc_reg;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic                   pc_at_max;
  logic [INSTR_WIDTH-1:0] instr_reg;
  logic [CNT_WIDTH-1:0]   count_reg;
  logic                   wrap_reg;
  logic                   start_ok;
  logic                   rsp_take;
  logic                   retire;

  pc_fetch_sequencer_inc #(.WIDTH(PC_WIDTH)) u_inc (
    .pc       (pc_reg),
    .pc_plus1 (pc_inc),
    .pc_max   (pc_at_max)
  );

  assign start_ok = Start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign rsp_take = (state_reg == ST_WAIT_RSP) && MemRspValid;
  assign retire   = (state_reg == ST_EXEC) && ExecDone;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (Start)       state_next = ST_FETCH;
      ST_FETCH:         if (MemReqReady) state_next = ST_WAIT_RSP;
      ST_WAIT_RSP:      if (MemRspValid) state_next = ST_EXEC;
      ST_EXEC:          if (ExecDone)    state_next = Halt ? ST_DONE : ST_FETCH;
      default:                           state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    MemReqValid = 1'b0;
    ExecValid   = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (state_reg)
      ST_FETCH:    begin MemReqValid = 1'b1; Busy = 1'b1; end
      ST_WAIT_RSP: Busy = 1'b1;
      ST_EXEC:     begin ExecValid = 1'b1; Busy = 1'b1; end
      ST_DONE:     Done = 1'b1;
      default:     ;
    endcase
  end

  // Halt takes priority over a simultaneous branch; only sequential steps can wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= '0;
      instr_reg <= '0;
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      if (start_ok) begin
        pc_reg    <= StartPC;
        count_reg <= '0;
        wrap_reg  <= 1'b0;
      end
      if (rsp_take) instr_reg <= MemRspData;
      if (retire) begin
        if (!(&count_reg)) count_reg <= count_reg + 1'b1;
        if (!Halt) begin
          if (BranchTaken) begin
            pc_reg <= BranchTarget;
          end else begin
            pc_reg <= pc_inc;
            if (pc_at_max) wrap_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign MemAddr      = pc_reg;
  assign CurrentPC    = pc_reg;
  assign Instr        = instr_reg;
  assign PcWrap       = wrap_reg;
  assign RetiredCount = count_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed instruction table, async reset case,
// then random programs checked against a transaction-level model.
module tb_pc_fetch_sequencer;

  localparam int PW = 8;
  localparam int IW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Start = 1'b0;
  logic [PW-1:0] StartPC = '0;
  logic          MemReqValid;
  logic          MemReqReady = 1'b0;
  logic [PW-1:0] MemAddr;
  logic          MemRspValid = 1'b0;
  logic [IW-1:0] MemRspData = '0;
  logic [IW-1:0] Instr;
  logic          ExecValid;
  logic          ExecDone = 1'b0;
  logic          BranchTaken = 1'b0;
  logic [PW-1:0] BranchTarget = '0;
  logic          Halt = 1'b0;
  logic [PW-1:0] CurrentPC;
  logic          Busy;
  logic          Done;
  logic          PcWrap;
  logic [CW-1:0] RetiredCount;

  pc_fetch_sequencer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .Start(Start), .StartPC(StartPC),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemAddr(MemAddr),
    .MemRspValid(MemRspValid), .MemRspData(MemRspData), .Instr(Instr),
    .ExecValid(ExecValid), .ExecDone(ExecDone), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Halt(Halt), .CurrentPC(CurrentPC),
    .Busy(Busy), .Done(Done), .PcWrap(PcWrap), .RetiredCount(RetiredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;     // issue Start with StartPC = addr before this instruction
    logic [PW-1:0] addr;      // expected fetch address
    int unsigned   ready_dly;
    int unsigned   rsp_dly;
    int unsigned   done_dly;
    logic [IW-1:0] data;
    logic          branch;
    logic          halt;
    logic [PW-1:0] target;
    logic          poke;      // stray Start/MemRspValid/ExecDone that must be ignored
    logic [PW-1:0] exp_pc;
    logic          exp_wrap;
    int unsigned   exp_cnt;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  string ctx = "init";

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", ctx, name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PW-1:0] pc);
    Start = 1'b1; StartPC = pc;
    step();
    Start = 1'b0;
    check("start busy", Busy, 1);
    check("start done", Done, 0);
    check("start wrap", PcWrap, 0);
    check("start count", RetiredCount, 0);
    check("start pc", CurrentPC, pc);
  endtask

  task automatic do_instr(input vec_t v);
    if (v.start) do_start(v.addr);
    check("req_valid", MemReqValid, 1);
    check("addr", MemAddr, v.addr);
    for (int i = 0; i < int'(v.ready_dly); i++) begin
      MemReqReady = 1'b0;
      if (v.poke) begin
        MemRspValid = 1'b1; MemRspData = ~v.data; ExecDone = 1'b1; Halt = 1'b1;
        Start = 1'b1; StartPC = 8'hA5;
      end
      step();
      MemRspValid = 1'b0; ExecDone = 1'b0; Halt = 1'b0; Start = 1'b0;
      check("bp req_valid", MemReqValid, 1);
      check("bp addr", MemAddr, v.addr);
    end
    MemReqReady = 1'b1;
    step();
    MemReqReady = 1'b0;
    check("wait req_valid", MemReqValid, 0);
    check("wait exec_valid", ExecValid, 0);
    for (int i = 0; i < int'(v.rsp_dly); i++) begin
      if (v.poke) begin Start = 1'b1; StartPC = 8'h5A; ExecDone = 1'b1; end
      step();
      Start = 1'b0; ExecDone = 1'b0;
      check("rsp wait busy", Busy, 1);
    end
    MemRspValid = 1'b1; MemRspData = v.data;
    step();
    MemRspValid = 1'b0; MemRspData = IW'($urandom);
    check("exec_valid", ExecValid, 1);
    check("instr", Instr, v.data);
    for (int i = 0; i < int'(v.done_dly); i++) begin
      if (v.poke) begin MemRspValid = 1'b1; MemRspData = ~v.data; Start = 1'b1; end
      step();
      MemRspValid = 1'b0; Start = 1'b0;
      check("instr hold", Instr, v.data);
      check("exec hold", ExecValid, 1);
    end
    ExecDone = 1'b1; BranchTaken = v.branch; Halt = v.halt; BranchTarget = v.target;
    step();
    ExecDone = 1'b0; BranchTaken = 1'b0; Halt = 1'b0;
    check("cur_pc", CurrentPC, v.exp_pc);
    check("wrap", PcWrap, v.exp_wrap);
    check("count", RetiredCount, v.exp_cnt);
    check("done", Done, v.halt);
    check("refetch", MemReqValid, !v.halt);
  endtask

  function automatic vec_t mk(input logic st, input logic [PW-1:0] a, input int unsigned rd,
                              input int unsigned sd, input int unsigned dd, input logic [IW-1:0] d,
                              input logic br, input logic h, input logic [PW-1:0] t, input logic pk,
                              input logic [PW-1:0] epc, input logic ew, input int unsigned ec);
    vec_t v;
    v.start = st; v.addr = a; v.ready_dly = rd; v.rsp_dly = sd; v.done_dly = dd;
    v.data = d; v.branch = br; v.halt = h; v.target = t; v.poke = pk;
    v.exp_pc = epc; v.exp_wrap = ew; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(1, 8'h10, 0, 0, 0, 16'h1111, 0, 0, 8'h00, 0, 8'h11, 0, 1);
    tbl[1]  = mk(0, 8'h11, 0, 0, 0, 16'h2222, 0, 0, 8'h00, 0, 8'h12, 0, 2);
    tbl[2]  = mk(0, 8'h12, 0, 0, 0, 16'h3333, 0, 1, 8'h00, 0, 8'h12, 0, 3);
    tbl[3]  = mk(1, 8'h05, 0, 0, 0, 16'h4444, 1, 0, 8'h40, 0, 8'h40, 0, 1);
    tbl[4]  = mk(0, 8'h40, 4, 3, 2, 16'h5555, 0, 0, 8'h00, 1, 8'h41, 0, 2);
    tbl[5]  = mk(0, 8'h41, 1, 0, 1, 16'h6666, 1, 0, 8'h08, 0, 8'h08, 0, 3);
    tbl[6]  = mk(0, 8'h08, 0, 1, 0, 16'h7777, 1, 1, 8'h77, 1, 8'h08, 0, 4);
    tbl[7]  = mk(1, 8'hFF, 0, 0, 0, 16'h8888, 0, 0, 8'h00, 0, 8'h00, 1, 1);
    tbl[8]  = mk(0, 8'h00, 0, 0, 0, 16'h9999, 1, 0, 8'hFF, 0, 8'hFF, 1, 2);
    tbl[9]  = mk(0, 8'hFF, 0, 0, 0, 16'hAAAA, 0, 1, 8'h00, 0, 8'hFF, 1, 3);
    tbl[10] = mk(1, 8'h30, 0, 0, 0, 16'hBBBB, 1, 0, 8'hFF, 0, 8'hFF, 0, 1);
    tbl[11] = mk(0, 8'hFF, 2, 0, 0, 16'hCCCC, 1, 0, 8'h00, 0, 8'h00, 0, 2);
    tbl[12] = mk(0, 8'h00, 0, 0, 0, 16'hDDDD, 0, 1, 8'h00, 0, 8'h00, 0, 3);

    // Reset state
    ctx = "reset";
    #2 reset = 1'b1;
    #1;
    check("rst busy", Busy, 0);
    check("rst req_valid", MemReqValid, 0);
    step(); step();
    reset = 1'b0;
    step();
    check("idle busy", Busy, 0);
    check("idle done", Done, 0);
    check("idle req_valid", MemReqValid, 0);
    check("idle exec_valid", ExecValid, 0);
    check("idle pc", CurrentPC, 0);
    check("idle instr", Instr, 0);
    check("idle count", RetiredCount, 0);
    check("idle wrap", PcWrap, 0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      ctx = $sformatf("vec%0d", i);
      do_instr(tbl[i]);
      $display("vec %0d: addr=0x%0h data=0x%0h br=%0b halt=%0b -> pc=0x%0h cnt=%0d wrap=%0b",
               i, tbl[i].addr, tbl[i].data, tbl[i].branch, tbl[i].halt,
               CurrentPC, RetiredCount, PcWrap);
    end

    // Asynchronous reset while waiting for a response; the late response must be dropped
    ctx = "async_reset";
    do_start(8'h20);
    MemReqReady = 1'b1;
    step();
    MemReqReady = 1'b0;
    check("pre busy", Busy, 1);
    #2 reset = 1'b1;
    #1;
    check("ar busy", Busy, 0);
    check("ar pc", CurrentPC, 0);
    check("ar addr", MemAddr, 0);
    check("ar instr", Instr, 0);
    check("ar count", RetiredCount, 0);
    check("ar req_valid", MemReqValid, 0);
    check("ar exec_valid", ExecValid, 0);
    MemRspValid = 1'b1; MemRspData = 16'hBEEF;
    step();
    reset = 1'b0;
    step(); step();
    MemRspValid = 1'b0;
    check("post busy", Busy, 0);
    check("post done", Done, 0);
    check("post instr", Instr, 0);
    check("post req_valid", MemReqValid, 0);
    $display("async reset: busy=%0b instr=0x%0h", Busy, Instr);

    // Random programs against a transaction-level model
    for (int p = 0; p < 6; p++) begin
      logic [PW-1:0] m_pc;
      logic          m_wrap;
      int unsigned   m_cnt;
      int unsigned   n;
      m_pc = PW'($urandom);
      if ($urandom_range(0, 2) == 0) m_pc = 8'hFD;
      m_wrap = 1'b0;
      m_cnt = 0;
      n = (p == 0) ? 20 : $urandom_range(4, 24);
      for (int k = 0; k < int'(n); k++) begin
        vec_t v;
        ctx = $sformatf("rnd%0d.%0d", p, k);
        v.start = (k == 0);
        v.addr = m_pc;
        v.ready_dly = $urandom_range(0, 3);
        v.rsp_dly = $urandom_range(0, 3);
        v.done_dly = $urandom_range(0, 3);
        v.data = IW'($urandom);
        v.halt = (k == int'(n) - 1);
        v.branch = ($urandom_range(0, 3) == 0);
        v.target = PW'($urandom);
        v.poke = $urandom_range(0, 1) == 1;
        m_cnt = (m_cnt >= (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
        if (!v.halt) begin
          if (v.branch) m_pc = v.target;
          else begin
            if (m_pc == {PW{1'b1}}) m_wrap = 1'b1;
            m_pc = m_pc + 1'b1;
          end
        end
        v.exp_pc = m_pc;
        v.exp_wrap = m_wrap;
        v.exp_cnt = m_cnt;
        do_instr(v);
        $display("rnd %0d.%0d: addr=0x%0h br=%0b halt=%0b -> pc=0x%0h cnt=%0d wrap=%0b",
                 p, k, v.addr, v.branch, v.halt, CurrentPC, RetiredCount, PcWrap);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
